// File: rtl/hwt_seq_trigger.sv
// rtl/hwt_seq_trigger.sv - sequential masked-pattern trigger; HWT_AUTORELOAD_EN enables periodic re-arm after firing
module hwt_seq_trigger #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 8,
    parameter int MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] match_val,
    input  logic [WIDTH-1:0] match_mask,
    output logic             trig,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        COUNT = 2'b10,
        FIRED = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             trig_q;
    logic             hit;

`ifdef HWT_AUTORELOAD_EN
    logic [1:0] fire_q, fire_d;
`endif

    // An all-zero mask must never match, otherwise it would match everything.
    assign hit = (((din ^ match_val) & match_mask) == '0) && (match_mask != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            trig_q  <= 1'b0;
`ifdef HWT_AUTORELOAD_EN
            fire_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            trig_q  <= (state_d == FIRED);
`ifdef HWT_AUTORELOAD_EN
            fire_q  <= fire_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef HWT_AUTORELOAD_EN
        fire_d  = 2'd0;
`endif
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (arm) state_d = ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        count_d = ONE_C;
                        state_d = (THRESH == 1) ? FIRED : COUNT;
                    end
                end
                COUNT: begin
                    if (hit) begin
                        count_d = count_q + ONE_C;
                        if (count_d == THRESH_C) state_d = FIRED;
                    end else if (MODE == 0) begin
                        count_d = '0;
                        state_d = ARMED;
                    end
                end
                FIRED: begin
                    count_d = THRESH_C;
`ifdef HWT_AUTORELOAD_EN
                    // Fourth cycle in FIRED hands back to ARMED for the next round.
                    if (fire_q == 2'd3) begin
                        state_d = ARMED;
                        count_d = '0;
                    end else begin
                        fire_d = fire_q + 2'd1;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign trig  = trig_q;
    assign count = count_q;
    assign state = state_q;

endmodule

// File: doc/hwt_seq_trigger.md
Name: hwt_seq_trigger

Overview:
- Parametrised, sequential successor to the combinational 4-input trigger cell in the hardware-trojan benchmark suite.
- Watches a WIDTH-bit input bus for a masked pattern match and counts matches. The count runs either on consecutive cycles or cumulatively, depending on MODE.
- Asserts a registered trigger once the count reaches THRESH.
- Sits between the monitored signals and the payload logic. Detection benches use it as the reference "rare sequential trigger".

Parameters:
- WIDTH, 4, width of monitored bus din, match_val and match_mask (1..32).
- CNT_W, 8, match counter width; THRESH must fit, i.e. THRESH <= 2^CNT_W-1.
- THRESH, 8, match count at which trigger fires (>=1).
- MODE, 0, 0 = consecutive (a non-match resets the count); 1 = cumulative (a non-match holds the count).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; IDLE->ARMED.
- clear  in  1  synchronous clear to IDLE; highest priority after reset.
- din  in  WIDTH  monitored bus.
- match_val  in  WIDTH  pattern value.
- match_mask  in  WIDTH  1 = bit compared, 0 = don't care.
- trig  out  1  registered trigger, high while in FIRED.
- count  out  CNT_W  current match count.
- state  out  2  FSM state encoding.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE (2'b00), count=0, trig=0.
- Match definition (combinational): hit = (((din ^ match_val) & match_mask) == 0) && (match_mask != 0). An all-zero mask never matches.
- State encodings: IDLE=00, ARMED=01, COUNT=10, FIRED=11.
- IDLE:
  - count held at 0; trig=0.
  - arm=1 -> ARMED next cycle.
  - din ignored.
- ARMED:
  - hit -> count=1 and go to COUNT.
  - If THRESH==1, hit goes directly to FIRED with count=1.
  - No hit -> stay.
- COUNT:
  - hit -> count+1. When count+1 == THRESH, go to FIRED on the same edge.
  - No hit, MODE=0 -> count=0, return to ARMED.
  - No hit, MODE=1 -> count held, stay in COUNT.
- FIRED:
  - trig=1; count saturates at THRESH; din ignored.
  - Leaves only on clear (or per Optional Feature).
- Latency: trig rises on the clock edge that samples the THRESH-th qualifying hit. trig is registered and has no combinational path from din.
- clear=1 in any state -> IDLE, count=0, trig=0 next edge. It overrides arm and hit in the same cycle.
- arm while not in IDLE: ignored.
- Counter never wraps: bounded by THRESH and saturating.
- rst_n deasserted mid-count: all progress lost, restarts at IDLE.
- Mask or pattern may change at any cycle; hit is evaluated with the values sampled that cycle.

Optional Feature:
- Macro: HWT_AUTORELOAD_EN.
- Defined:
  - FIRED lasts exactly 4 cycles (trig high 4 cycles).
  - Then returns to ARMED with count=0, giving periodic re-triggering.
  - clear still overrides at any point.
- Undefined: FIRED is sticky until clear or reset.

Test Plan:
- Reset/idle: rst_n=0 mid-run with count=5 -> state=00, count=0, trig=0 immediately. Then din=match_val with no arm -> stays IDLE, count=0.
- Consecutive fire: MODE=0, THRESH=8, mask=4'hF, val=4'hA. Arm, then 8 cycles din=4'hA -> count 1..8, trig=1 on the 8th sampling edge, state=11.
- Consecutive break: MODE=0, 5 hits, 1 miss, 8 hits -> count drops to 0 and state returns to 01 after the miss; trig only after the final 8th hit.
- Cumulative: MODE=1, THRESH=8. Hits interleaved with misses (H,M,H,H,M,...) -> count holds on misses; trig after the 8th hit total.
- Masking/boundary:
  - mask=4'b0011, val=4'b0001: din=4'b1101 hits.
  - mask=0 never hits.
  - THRESH=1: single hit -> FIRED directly from ARMED.
- Clear priority / autoreload:
  - clear asserted in the same cycle as the final hit -> IDLE, trig stays 0.
  - With HWT_AUTORELOAD_EN: trig high exactly 4 cycles, then state=01, count=0.
